// File: rtl/cpu_bus_responder_if.sv
// Bus bundle between the CPU/UART side and cpu_bus_responder.
// master = CPU + UART glue side, slave = responder.
interface cpu_bus_responder_if;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        program_stop;

  modport master (
    output mem_a, mem_dout, mem_wr, tx_ready, rx_data, rx_valid,
    input  mem_din, io_buffer_full, tx_data, tx_valid, rx_ready, program_stop
  );
  modport slave (
    input  mem_a, mem_dout, mem_wr, tx_ready, rx_data, rx_valid,
    output mem_din, io_buffer_full, tx_data, tx_valid, rx_ready, program_stop
  );
endinterface

// File: rtl/cpu_bus_responder.sv
// Byte-bus responder: on-chip RAM, UART TX FIFO / RX holding byte, stop flag.
// Define CYCLE_COUNTER_EN to build the cycle counter readback at 0x30004..7.
module cpu_bus_responder #(
  parameter int RAM_ADDR_W  = 17,
  parameter int TX_FIFO_LOG = 4
) (
  input  logic clk_in,
  input  logic rst_in,
  cpu_bus_responder_if.slave bus
);
  localparam int DEPTH = 2**TX_FIFO_LOG;
  localparam logic [TX_FIFO_LOG:0] CNT_FULL = (TX_FIFO_LOG+1)'(DEPTH);
  localparam logic [TX_FIFO_LOG:0] CNT_HI   = (TX_FIFO_LOG+1)'(DEPTH-2);

  logic [7:0]             ram  [2**RAM_ADDR_W];
  logic [7:0]             fifo [DEPTH];
  logic [TX_FIFO_LOG-1:0] wr_ptr, rd_ptr;
  logic [TX_FIFO_LOG:0]   cnt;
  logic [7:0]             hold, din_q, rd_data, push_d;
  logic                   hold_vld, stop_q;

  wire unused_addr = &{1'b0, bus.mem_a[31:18]};

  wire       is_ram  = ~bus.mem_a[17];
  wire       is_io   = bus.mem_a[17:16] == 2'b11;
  wire [2:0] io_off  = bus.mem_a[2:0];
  wire       io_wr   = is_io & bus.mem_wr;
  wire       io_rd   = is_io & ~bus.mem_wr;
  wire       tx_wr   = io_wr & (io_off == 3'd0) & (bus.mem_dout != 8'h00);
  wire       stop_wr = io_wr & (io_off == 3'd4);
  wire       push    = tx_wr | stop_wr;
  wire       pop     = bus.tx_valid & bus.tx_ready;
  // a pop frees the slot in the same edge, so a full FIFO still accepts
  wire       push_ok = push & ((cnt != CNT_FULL) | pop);
  wire       rx_rd   = io_rd & (io_off == 3'd0);
  wire       cap     = bus.rx_valid & ~hold_vld;

  assign push_d = stop_wr ? 8'h00 : bus.mem_dout;

`ifdef CYCLE_COUNTER_EN
  logic [31:0] cyc_cnt, snap;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cyc_cnt <= '0;
      snap    <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (io_rd && io_off == 3'd4) snap <= cyc_cnt;
    end
  end
`endif

  always_comb begin
    rd_data = 8'h00;
    if (is_ram) rd_data = ram[bus.mem_a[RAM_ADDR_W-1:0]];
    else if (is_io) begin
      case (io_off)
        3'd0: rd_data = hold_vld ? hold : 8'h00;
`ifdef CYCLE_COUNTER_EN
        // byte 0 comes live; upper bytes from the snapshot taken with it
        3'd4: rd_data = cyc_cnt[7:0];
        3'd5: rd_data = snap[15:8];
        3'd6: rd_data = snap[23:16];
        3'd7: rd_data = snap[31:24];
`endif
        default: rd_data = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (is_ram && bus.mem_wr) ram[bus.mem_a[RAM_ADDR_W-1:0]] <= bus.mem_dout;
    if (push_ok) fifo[wr_ptr] <= push_d;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      hold     <= 8'h00;
      hold_vld <= 1'b0;
      stop_q   <= 1'b0;
      din_q    <= 8'h00;
    end else begin
      din_q <= rd_data;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      // capture only happens when empty, so a coincident read saw 0x00
      if (cap) begin
        hold     <= bus.rx_data;
        hold_vld <= 1'b1;
      end else if (rx_rd) hold_vld <= 1'b0;
      if (stop_wr) stop_q <= 1'b1;
    end
  end

  assign bus.mem_din        = din_q;
  assign bus.tx_data        = fifo[rd_ptr];
  assign bus.tx_valid       = cnt != '0;
  assign bus.io_buffer_full = cnt >= CNT_HI;
  assign bus.rx_ready       = ~hold_vld;
  assign bus.program_stop   = stop_q;
endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed self-checking bench for cpu_bus_responder.
// Counter expectations follow CYCLE_COUNTER_EN like the RTL build.
module tb_cpu_bus_responder;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  cpu_bus_responder_if bus();
  cpu_bus_responder dut (.clk_in(clk_in), .rst_in(rst_in), .bus(bus));

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drv(input logic wr, input logic [31:0] a, input logic [7:0] d);
    bus.mem_wr   = wr;
    bus.mem_a    = a;
    bus.mem_dout = d;
  endtask

  task automatic idle();
    drv(1'b0, 32'h0, 8'h00);
  endtask

  logic [7:0] last;
  int         n;
  logic [7:0] exp_cnt [4];

  initial begin
    bus.tx_ready = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    idle();
    cyc(); cyc();
    chk("rst_din", bus.mem_din, 0);
    chk("rst_txv", bus.tx_valid, 0);
    chk("rst_full", bus.io_buffer_full, 0);
    chk("rst_rxr", bus.rx_ready, 1);
    chk("rst_stop", bus.program_stop, 0);
    rst_in = 1'b0;

    // counter is 0 now; sample the dword in cycles 10..13
`ifdef CYCLE_COUNTER_EN
    exp_cnt = '{8'h0A, 8'h00, 8'h00, 8'h00};
`else
    exp_cnt = '{8'h00, 8'h00, 8'h00, 8'h00};
`endif
    repeat (10) cyc();
    for (int i = 0; i < 4; i++) begin
      drv(1'b0, 32'h30004 + i, 8'h00);
      cyc();
      chk($sformatf("cnt_b%0d", i), bus.mem_din, exp_cnt[i]);
    end

    // RAM read-after-write, unmapped region
    drv(1'b1, 32'h00010, 8'hA5); cyc();
    drv(1'b1, 32'h20010, 8'h33); cyc();
    drv(1'b0, 32'h00010, 8'h00); cyc();
    chk("ram_raw", bus.mem_din, 8'hA5);
    drv(1'b1, 32'h1FFFF, 8'h5A); cyc();
    drv(1'b0, 32'h1FFFF, 8'h00); cyc();
    chk("ram_top", bus.mem_din, 8'h5A);
    drv(1'b0, 32'h20010, 8'h00); cyc();
    chk("unmap_rd", bus.mem_din, 8'h00);

    // TX: zero byte ignored, then drain
    drv(1'b1, 32'h30000, 8'h41); cyc();
    drv(1'b1, 32'h30000, 8'h00); cyc();
    drv(1'b1, 32'h30000, 8'h42); cyc();
    idle();
    chk("tx_v", bus.tx_valid, 1);
    chk("tx_d0", bus.tx_data, 8'h41);
    chk("tx_nf", bus.io_buffer_full, 0);
    bus.tx_ready = 1'b1;
    cyc();
    chk("tx_d1", bus.tx_data, 8'h42);
    chk("tx_v1", bus.tx_valid, 1);
    cyc();
    chk("tx_empty", bus.tx_valid, 0);
    bus.tx_ready = 1'b0;

    // fill: nearly-full at 14, drop on full, push+pop when full
    for (int i = 0; i < 13; i++) begin
      drv(1'b1, 32'h30000, 8'h55); cyc();
    end
    chk("full_13", bus.io_buffer_full, 0);
    cyc();
    chk("full_14", bus.io_buffer_full, 1);
    cyc(); cyc();
    drv(1'b1, 32'h30000, 8'h77); cyc();
    drv(1'b1, 32'h30000, 8'h66);
    bus.tx_ready = 1'b1;
    cyc();
    idle();
    chk("full_keep", bus.io_buffer_full, 1);
    n = 0;
    last = 8'h00;
    while (bus.tx_valid && n < 40) begin
      last = bus.tx_data;
      n++;
      cyc();
    end
    chk("drain_n", n, 16);
    chk("drain_last", last, 8'h66);
    chk("drain_nf", bus.io_buffer_full, 0);
    bus.tx_ready = 1'b0;

    // RX holding register
    bus.rx_valid = 1'b1; bus.rx_data = 8'h7E; cyc();
    bus.rx_valid = 1'b0;
    chk("rx_hold", bus.rx_ready, 0);
    drv(1'b0, 32'h30000, 8'h00); cyc();
    chk("rx_rd", bus.mem_din, 8'h7E);
    chk("rx_rdy", bus.rx_ready, 1);
    cyc();
    chk("rx_rd2", bus.mem_din, 8'h00);
    bus.rx_valid = 1'b1; bus.rx_data = 8'h3C; cyc();
    bus.rx_valid = 1'b0;
    chk("rx_coinc", bus.mem_din, 8'h00);
    chk("rx_kept", bus.rx_ready, 0);
    cyc();
    chk("rx_rd3", bus.mem_din, 8'h3C);

    // stop flag, reset mid-drain
    drv(1'b1, 32'h30004, 8'h99); cyc();
    chk("stop", bus.program_stop, 1);
    chk("stop_txv", bus.tx_valid, 1);
    chk("stop_txd", bus.tx_data, 8'h00);
    drv(1'b1, 32'h30000, 8'h41); cyc();
    idle();
    bus.tx_ready = 1'b1;
    cyc();
    chk("stop_next", bus.tx_data, 8'h41);
    drv(1'b0, 32'h00010, 8'h00);
    rst_in = 1'b1;
    cyc();
    chk("mrst_txv", bus.tx_valid, 0);
    chk("mrst_stop", bus.program_stop, 0);
    chk("mrst_din", bus.mem_din, 8'h00);
    rst_in = 1'b0;
    bus.tx_ready = 1'b0;
    idle();
    cyc();
    chk("post_txv", bus.tx_valid, 0);
    chk("post_stop", bus.program_stop, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
